conv_ch_accum: RTL and testbench

CONV_CH_ACCUM -- requirements
Module: conv_ch_accum

---
 rtl/conv_ch_accum.sv | 104 ++++++++++
 tb/tb_conv_ch_accum.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ch_accum.sv
// Channel-accumulating convolution stage: multiplies N_LANE pixels by N_K weights per beat and
// accumulates over N_CH input channels. Each result is rounded, divided by N_CH and saturated.
module conv_ch_accum #(
  parameter int unsigned DW     = 16,
  parameter int unsigned N_LANE = 4,
  parameter int unsigned N_K    = 8,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned FRAC   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [N_LANE*DW-1:0]          i_data,
  input  logic [N_K*DW-1:0]             i_weight,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [N_K*N_LANE*DW-1:0]      o_result,
  output logic                          o_busy
);

  localparam int unsigned CW = $clog2(N_CH);
  localparam int unsigned AW = DW + CW;
  localparam logic signed [AW:0] RoundHalf = (AW+1)'(1) << (CW - 1);
  localparam logic signed [AW:0] MaxVal    = (AW+1)'({(DW-1){1'b1}});
  localparam logic signed [AW:0] MinVal    = ~MaxVal;

  typedef enum logic [0:0] {StAcc, StOut} state_e;

  state_e                     state_q;
  logic [CW-1:0]              ch_cnt_q;
  logic signed [AW-1:0]       acc_q [N_K][N_LANE];
  logic signed [AW-1:0]       acc_d [N_K][N_LANE];
  logic [N_K*N_LANE*DW-1:0]   res_q, res_d;
  logic                       accept, first_beat, last_beat;

  // Full-precision product, scaled down by FRAC, wrapped to DW bits, sign-extended to AW.
  function automatic logic signed [AW-1:0] scaled_prod(input logic signed [DW-1:0] d,
                                                       input logic signed [DW-1:0] w);
    logic signed [2*DW-1:0] full;
    logic signed [DW-1:0]   trunc;
    full  = d * w;
    full  = full >>> FRAC;
    trunc = full[DW-1:0];
    return trunc;
  endfunction

  // Round half up while dividing by N_CH, then clamp to the DW range.
  function automatic logic [DW-1:0] round_sat(input logic signed [AW-1:0] a);
    logic signed [AW:0] r;
    r = a;
    r = (r + RoundHalf) >>> CW;
    if (r > MaxVal) begin
      return {1'b0, {(DW-1){1'b1}}};
    end else if (r < MinVal) begin
      return {1'b1, {(DW-1){1'b0}}};
    end
    return r[DW-1:0];
  endfunction

  // In StOut a new beat may enter only in the cycle the pending result drains.
  assign o_ready    = (state_q == StAcc) | i_ready;
  assign accept     = i_valid & o_ready;
  assign first_beat = (ch_cnt_q == '0);
  assign last_beat  = (ch_cnt_q == CW'(N_CH - 1));

  always_comb begin
    acc_d = acc_q;
    res_d = '0;
    for (int k = 0; k < N_K; k++) begin
      for (int j = 0; j < N_LANE; j++) begin
        acc_d[k][j] = first_beat
                    ? scaled_prod(i_data[j*DW +: DW], i_weight[k*DW +: DW])
                    : acc_q[k][j] + scaled_prod(i_data[j*DW +: DW], i_weight[k*DW +: DW]);
        res_d[(k*N_LANE+j)*DW +: DW] = round_sat(acc_d[k][j]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StAcc;
      ch_cnt_q <= '0;
      res_q    <= '0;
      acc_q    <= '{default: '0};
    end else begin
      if (accept) begin
        acc_q    <= acc_d;
        ch_cnt_q <= last_beat ? '0 : ch_cnt_q + CW'(1);
      end
      if (accept && last_beat) begin
        res_q   <= res_d;
        state_q <= StOut;
      end else if (state_q == StOut && i_ready) begin
        state_q <= StAcc;
      end
    end
  end

  assign o_valid  = (state_q == StOut);
  assign o_result = res_q;
  assign o_busy   = (ch_cnt_q != '0);

endmodule

// File: tb/tb_conv_ch_accum.sv
// Directed bench for conv_ch_accum at default parameters: table of uniform-value groups with
// hand-computed results, plus gapped, backpressure and reset sequences against a small model.
module tb_conv_ch_accum;

  localparam int DW = 16;
  localparam int NL = 4;
  localparam int NK = 8;
  localparam int NC = 4;
  localparam int RW = NK * NL * DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_valid;
  logic            o_ready;
  logic [NL*DW-1:0] i_data;
  logic [NK*DW-1:0] i_weight;
  logic            o_valid;
  logic            i_ready;
  logic [RW-1:0]   o_result;
  logic            o_busy;

  conv_ch_accum dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .i_weight (i_weight),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic [NL*DW-1:0] bd [NC];
  logic [NK*DW-1:0] bw [NC];

  typedef struct {
    string       name;
    logic [15:0] d [NC];
    logic [15:0] w [NC];
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_beat(input int c);
    int   n;
    logic seen;
    n = 0;
    i_valid  = 1'b1;
    i_data   = bd[c];
    i_weight = bw[c];
    do begin
      @(negedge clk);
      seen = o_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!seen && n < 50);
    if (!seen) begin
      n_chk++;
      n_bad++;
      $display("FAIL beat_timeout: got o_ready=0 want 1");
    end
    i_valid = 1'b0;
  endtask

  task automatic fill_uniform(input vec_t v);
    for (int c = 0; c < NC; c++) begin
      bd[c] = {NL{v.d[c]}};
      bw[c] = {NK{v.w[c]}};
    end
  endtask

  task automatic fill_varied(input int s);
    for (int c = 0; c < NC; c++) begin
      for (int j = 0; j < NL; j++) bd[c][j*DW +: DW] = 16'(s*37 + c*291 + j*1110 - 2048);
      for (int k = 0; k < NK; k++) bw[c][k*DW +: DW] = 16'(k*113 - c*400 + 256 + s*50);
    end
  endtask

  function automatic logic [RW-1:0] model();
    logic [RW-1:0]    r;
    longint           s, p;
    logic signed [15:0] t;
    r = '0;
    for (int k = 0; k < NK; k++) begin
      for (int j = 0; j < NL; j++) begin
        s = 0;
        for (int c = 0; c < NC; c++) begin
          p = longint'($signed(bd[c][j*DW +: DW])) * longint'($signed(bw[c][k*DW +: DW]));
          p = p >>> 8;
          t = p[15:0];
          s = s + longint'(t);
        end
        s = (s + 2) >>> 2;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        r[(k*NL+j)*DW +: DW] = s[15:0];
      end
    end
    return r;
  endfunction

  task automatic set_vec(input int i, input string nm, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3, input logic [15:0] w0,
                         input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3,
                         input logic [15:0] e);
    vecs[i].name = nm;
    vecs[i].d[0] = d0; vecs[i].d[1] = d1; vecs[i].d[2] = d2; vecs[i].d[3] = d3;
    vecs[i].w[0] = w0; vecs[i].w[1] = w1; vecs[i].w[2] = w2; vecs[i].w[3] = w3;
    vecs[i].exp  = e;
  endtask

  logic [RW-1:0] exp_v;
  logic [6:0]    gap_pat;
  int            idx;

  initial begin
    set_vec(0,  "unity_x2",  16'h0100, 16'h0100, 16'h0100, 16'h0100,
                             16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200);
    set_vec(1,  "round_pos", 16'h0001, 16'h0001, 16'h0000, 16'h0000,
                             16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0001);
    set_vec(2,  "round_neg", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000,
                             16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'hFFFF);
    set_vec(3,  "trunc_wrap", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                             16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFF00);
    set_vec(4,  "half_scale", 16'h4000, 16'h4000, 16'h4000, 16'h4000,
                             16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0080);
    set_vec(5,  "pos_max",   16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                             16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h7FFF);
    set_vec(6,  "neg_min",   16'h8000, 16'h8000, 16'h8000, 16'h8000,
                             16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h8000);
    set_vec(7,  "mixed",     16'h0300, 16'hFF00, 16'h0080, 16'h0100,
                             16'h0100, 16'h0200, 16'hFE00, 16'h0100, 16'h0040);
    set_vec(8,  "half_up",   16'hFFFE, 16'h0000, 16'h0000, 16'h0000,
                             16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000);
    set_vec(9,  "frac_prod", 16'h0180, 16'h0180, 16'h0180, 16'h0180,
                             16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0240);
    set_vec(10, "neg_shift", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                             16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF);

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_data = '0; i_weight = '0;
    #3;
    check("rst_o_ready", RW'(o_ready), RW'(1));
    check("rst_o_valid", RW'(o_valid), RW'(0));
    check("rst_o_busy", RW'(o_busy), RW'(0));
    check("rst_o_result", o_result, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back groups with the result drained every time.
    for (int v = 0; v < 11; v++) begin
      fill_uniform(vecs[v]);
      for (int c = 0; c < NC; c++) begin
        do_beat(c);
        if (v == 0 && c < NC - 1) check("busy_mid_group", RW'(o_busy), RW'(1));
      end
      check({vecs[v].name, "_valid"}, RW'(o_valid), RW'(1));
      exp_v = {(NK*NL){vecs[v].exp}};
      check(vecs[v].name, o_result, exp_v);
    end
    @(posedge clk); #1;
    check("drained_valid", RW'(o_valid), RW'(0));
    check("drained_busy", RW'(o_busy), RW'(0));

    // Distinct values per lane and kernel.
    fill_varied(1);
    for (int c = 0; c < NC; c++) do_beat(c);
    check("varied_result", o_result, model());
    @(posedge clk); #1;

    // Gapped input must match the ungapped reference.
    fill_varied(2);
    gap_pat = 7'b1101001;
    idx = 0;
    for (int t = 0; t < 7; t++) begin
      i_valid  = gap_pat[t];
      i_data   = gap_pat[t] ? bd[idx] : {NL{16'h5A5A}};
      i_weight = gap_pat[t] ? bw[idx] : {NK{16'hA5A5}};
      @(posedge clk); #1;
      if (gap_pat[t]) idx++;
      if (t == 5) check("gap_no_early_valid", RW'(o_valid), RW'(0));
    end
    i_valid = 1'b0;
    check("gap_valid", RW'(o_valid), RW'(1));
    check("gap_result", o_result, model());

    // Backpressure: held result, ignored beats, then drain-and-accept in one cycle.
    @(posedge clk); #1;
    fill_uniform(vecs[0]);
    for (int c = 0; c < NC; c++) do_beat(c);
    exp_v = {(NK*NL){16'h0200}};
    i_ready  = 1'b0;
    i_valid  = 1'b1;
    i_data   = {NL{16'h7FFF}};
    i_weight = {NK{16'h7FFF}};
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("bp_o_ready", RW'(o_ready), RW'(0));
      check("bp_o_valid", RW'(o_valid), RW'(1));
      check("bp_hold_result", o_result, exp_v);
      @(posedge clk); #1;
    end
    check("bp_busy_idle", RW'(o_busy), RW'(0));
    fill_uniform(vecs[1]);
    i_ready = 1'b1;
    do_beat(0);
    check("bp_drain_valid", RW'(o_valid), RW'(0));
    check("bp_drain_busy", RW'(o_busy), RW'(1));
    for (int c = 1; c < NC; c++) do_beat(c);
    check("bp_next_result", o_result, {(NK*NL){16'h0001}});

    // Reset mid-group discards the partial sum.
    @(posedge clk); #1;
    fill_varied(3);
    do_beat(0);
    do_beat(1);
    check("mid_busy", RW'(o_busy), RW'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", RW'(o_busy), RW'(0));
    check("mid_rst_ready", RW'(o_ready), RW'(1));
    check("mid_rst_result", o_result, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    fill_varied(4);
    for (int c = 0; c < NC; c++) begin
      do_beat(c);
      if (c < NC - 1) check("mid_no_spurious_valid", RW'(o_valid), RW'(0));
    end
    check("mid_valid", RW'(o_valid), RW'(1));
    check("mid_result_b_only", o_result, model());

    // Reset while a result is pending drops it.
    i_ready = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("out_rst_valid", RW'(o_valid), RW'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    i_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      check("out_rst_stays_idle", RW'(o_valid), RW'(0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
